// File: rtl/restoring_divider_if.sv
// Start/busy/done bundle for the sequential restoring divider.
// Ready rule: start is taken on a rising clk edge whenever busy is low; operands are sampled on that edge only.
interface restoring_divider_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic [1:0]       state_dbg;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, state_dbg
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, state_dbg
    );
endinterface

// File: rtl/restoring_divider.sv
// Unsigned restoring divider producing one quotient bit per clock.
// Each trial subtract is an add of the inverted divisor with carry-in 1.
module restoring_divider #(
    parameter int WIDTH = 8
) (
    input logic                clk,
    input logic                rst,
    restoring_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    // The partial remainder stays below the divisor, so its top bit is always zero
    // between steps; only the shifted value needs the extra bit.
    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   trial;
    logic             trial_ok;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;
    logic             accept;
    logic             last_step;

    logic [WIDTH-1:0] quotient_reg;
    logic [WIDTH-1:0] remainder_reg;
    logic             dbz_reg;

    assign accept    = bus.start && (state != RUN);
    assign last_step = (state == RUN) && (count == CW'(1));

    always_comb begin
        r_shift  = {r_reg, q_reg[WIDTH-1]};
        trial    = r_shift + ~{1'b0, d_reg} + {{WIDTH{1'b0}}, 1'b1};
        trial_ok = ~trial[WIDTH];
        r_next   = trial_ok ? trial[WIDTH-1:0] : r_shift[WIDTH-1:0];
        q_next   = {q_reg[WIDTH-2:0], trial_ok};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_next = (bus.divisor == '0) ? DONE : RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (count == CW'(1)) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_reg         <= '0;
            q_reg         <= '0;
            d_reg         <= '0;
            count         <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
        end else if (accept) begin
            r_reg <= '0;
            q_reg <= bus.dividend;
            d_reg <= bus.divisor;
            count <= CW'(WIDTH);
            // A zero divisor completes on the accepting edge with saturated quotient.
            if (bus.divisor == '0) begin
                quotient_reg  <= '1;
                remainder_reg <= bus.dividend;
                dbz_reg       <= 1'b1;
            end
        end else if (state == RUN) begin
            r_reg <= r_next;
            q_reg <= q_next;
            count <= count - CW'(1);
            if (last_step) begin
                quotient_reg  <= q_next;
                remainder_reg <= r_next;
                dbz_reg       <= 1'b0;
            end
        end
    end

    assign bus.busy        = (state == RUN);
    assign bus.done        = (state == DONE);
    assign bus.quotient    = quotient_reg;
    assign bus.remainder   = remainder_reg;
    assign bus.div_by_zero = dbz_reg;
    assign bus.state_dbg   = state;
endmodule

// File: tb/tb_restoring_divider.sv
// Bench for restoring_divider: directed cases with literal results, then random
// pin activity checked every cycle against an arithmetic model.
module tb_restoring_divider;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    restoring_divider_if #(.WIDTH(W)) bus ();

    restoring_divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- model ----------------
    int             m_left = 0;
    bit             m_done = 1'b0;
    logic [W-1:0]   m_q = '0;
    logic [W-1:0]   m_r = '0;
    logic [W-1:0]   p_q = '0;
    logic [W-1:0]   p_r = '0;
    logic [2*W:0]   exp_q[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left = 0;
            m_done = 1'b0;
            m_q    = '0;
            m_r    = '0;
            exp_q.delete();
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1'b1;
                    m_q    = p_q;
                    m_r    = p_r;
                end
            end else if (bus.start) begin
                if (bus.divisor == 0) begin
                    p_q    = 8'd255;
                    p_r    = bus.dividend;
                    m_done = 1'b1;
                    m_q    = p_q;
                    m_r    = p_r;
                    exp_q.push_back({1'b1, p_q, p_r});
                end else begin
                    p_q    = bus.dividend / bus.divisor;
                    p_r    = bus.dividend % bus.divisor;
                    m_left = W;
                    exp_q.push_back({1'b0, p_q, p_r});
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [2*W:0] e;
    always @(negedge clk) begin
        if (!rst) begin
            chk("busy", {31'd0, bus.busy}, {31'd0, m_left > 0});
            chk("done", {31'd0, bus.done}, {31'd0, m_done});
            chk("busy_done_excl", {31'd0, bus.busy & bus.done}, 32'd0);
            chk("quotient_hold", {24'd0, bus.quotient}, {24'd0, m_q});
            chk("remainder_hold", {24'd0, bus.remainder}, {24'd0, m_r});
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL done_without_request at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("res_quotient", {24'd0, bus.quotient}, {24'd0, e[2*W-1:W]});
                    chk("res_remainder", {24'd0, bus.remainder}, {24'd0, e[W-1:0]});
                    chk("res_div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, e[2*W]});
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = W'($urandom);
        bus.divisor  = W'($urandom);
    endtask

    task automatic wait_done(output int busy_n);
        int n;
        bit got;
        n      = 0;
        got    = 1'b0;
        busy_n = 0;
        while (!got && n < 30) begin
            if (bus.done) begin
                got = 1'b1;
            end else begin
                if (bus.busy) busy_n++;
                @(negedge clk);
                n++;
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_done: no done within 30 cycles at %0t", $time);
        end
    endtask

    task automatic op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] eq, input logic [W-1:0] er, input bit ez,
                      input int exp_busy);
        int bn;
        issue(a, b);
        wait_done(bn);
        chk({name, "_busy_cycles"}, bn, exp_busy);
        chk({name, "_q"}, {24'd0, bus.quotient}, {24'd0, eq});
        chk({name, "_r"}, {24'd0, bus.remainder}, {24'd0, er});
        chk({name, "_dbz"}, {31'd0, bus.div_by_zero}, {31'd0, ez});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int  bn;
        bit  saw;
        int  sel;

        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        rst          = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        chk("reset_done", {31'd0, bus.done}, 32'd0);
        chk("reset_q", {24'd0, bus.quotient}, 32'd0);
        chk("reset_r", {24'd0, bus.remainder}, 32'd0);
        chk("reset_dbz", {31'd0, bus.div_by_zero}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        op("d180_9", 8'd180, 8'd9, 8'd20, 8'd0, 1'b0, 8);
        @(negedge clk);
        chk("done_one_cycle", {31'd0, bus.done}, 32'd0);

        op("d228_219", 8'd228, 8'd219, 8'd1, 8'd9, 1'b0, 8);
        op("d56_9_b2b", 8'd56, 8'd9, 8'd6, 8'd2, 1'b0, 8);
        @(negedge clk);

        op("d255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 8);
        @(negedge clk);
        op("d7_9", 8'd7, 8'd9, 8'd0, 8'd7, 1'b0, 8);
        @(negedge clk);

        op("d78_0", 8'd78, 8'd0, 8'd255, 8'd78, 1'b1, 0);
        @(negedge clk);
        op("d78_3", 8'd78, 8'd3, 8'd26, 8'd0, 1'b0, 8);
        @(negedge clk);

        // start held high through RUN with new operands; taken again only in DONE
        bus.start    = 1'b1;
        bus.dividend = 8'd90;
        bus.divisor  = 8'd9;
        @(negedge clk);
        bus.dividend = 8'd67;
        wait_done(bn);
        chk("hold_busy_cycles", bn, 8);
        chk("hold_first_q", {24'd0, bus.quotient}, 32'd10);
        chk("hold_first_r", {24'd0, bus.remainder}, 32'd0);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(bn);
        chk("hold_second_q", {24'd0, bus.quotient}, 32'd7);
        chk("hold_second_r", {24'd0, bus.remainder}, 32'd4);
        @(negedge clk);

        // abort at RUN cycle 4
        issue(8'd99, 8'd2);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_done", {31'd0, bus.done}, 32'd0);
        chk("abort_q", {24'd0, bus.quotient}, 32'd0);
        chk("abort_r", {24'd0, bus.remainder}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        saw = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done) saw = 1'b1;
        end
        chk("abort_no_done", {31'd0, saw}, 32'd0);
        op("d99_2_retry", 8'd99, 8'd2, 8'd49, 8'd1, 1'b0, 8);
        @(negedge clk);

        // random pin activity, including starts held through RUN and zero divisors
        repeat (12000) begin
            bus.start = ($urandom_range(0, 3) == 0);
            sel = $urandom_range(0, 15);
            case (sel)
                0:       bus.divisor = 8'd0;
                1:       bus.divisor = 8'd1;
                2:       bus.divisor = 8'd255;
                default: bus.divisor = W'($urandom_range(1, 255));
            endcase
            sel = $urandom_range(0, 7);
            case (sel)
                0:       bus.dividend = 8'd0;
                1:       bus.dividend = 8'd255;
                default: bus.dividend = W'($urandom);
            endcase
            @(negedge clk);
        end
        bus.start = 1'b0;
        repeat (12) @(negedge clk);
        chk("drain_queue_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
